// File: rtl/dsp_mac_seq_pkg.sv
// dsp_mac_seq_pkg
// Shared definitions for the DSP-slice MAC sequencer: controller state
// encoding, the per-slot tag carried alongside the slice pipeline, and the
// slice OPMODE values used to start and continue an accumulation.
package dsp_mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // One tag per slot issued into the slice; follows the operand through
  // the A1/B1 and M register stages.
  typedef struct packed {
    logic live;   // slot carries a real operand pair
    logic first;  // slot is the first pair of its vector
  } tag_t;

  localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0 : restart sum
  localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P : accumulate

endpackage

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq
// Sequencer that streams signed 18x18 operand pairs into an external DSP
// slice (A1/B1/M/P/OPMODE registered, latency DSP_LAT) and presents the
// dot product of each vector once the slice has finished summing it.
//
// Ports
//   clk, RST                 clock, async active-high reset
//   s_valid/s_ready/s_last   operand stream handshake, s_last ends a vector
//   s_a, s_b                 signed operand pair
//   dsp_a, dsp_b             slice A/B inputs (zero when nothing issued)
//   dsp_opmode               slice OPMODE, one cycle after the matching issue
//   dsp_ce, dsp_cep          slice CEA/CEB/CEM/CEOPMODE and CEP
//   dsp_rst                  slice synchronous reset
//   dsp_p                    slice P output
//   m_valid/m_ready          result handshake
//   m_data, m_count          48-bit sum and number of pairs (saturating)
module dsp_mac_seq
  import dsp_mac_seq_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DSP_LAT = 3
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             s_valid,
  input  logic             s_last,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  output logic             s_ready,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_cep,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [47:0]      m_data,
  output logic [CNT_W-1:0] m_count
);

  localparam int DW = $clog2(DSP_LAT + 1);
  // DRAIN spans DSP_LAT-1 cycles; counter runs 0 .. DSP_LAT-2.
  localparam logic [DW-1:0] DRAIN_END = DW'(DSP_LAT - 2);

  state_e           state_q;
  tag_t [1:0]       tag_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    drain_q;
  logic [7:0]       opm_q;
  logic             rst_q;
  logic             xfer, first;

  // rst_q keeps the slice in reset for the first edge after RST drops, and
  // blocks operand accept during that cycle so no pair is lost to it.
  assign s_ready = (state_q == IDLE || state_q == ACCUM) && !rst_q;
  assign xfer    = s_valid && s_ready;
  assign first   = xfer && (state_q == IDLE);

  assign dsp_a      = xfer ? s_a : '0;
  assign dsp_b      = xfer ? s_b : '0;
  assign dsp_opmode = opm_q;
  assign dsp_ce     = (state_q != HOLD) && !rst_q;
  assign dsp_cep    = (state_q == ACCUM) || (state_q == DRAIN);
  assign dsp_rst    = rst_q;

  // P holds still in HOLD because CEP is low there.
  assign m_valid = (state_q == HOLD);
  assign m_data  = m_valid ? dsp_p : '0;
  assign m_count = m_valid ? cnt_q : '0;

  // Pairs are counted as they land in P (tag stage 1 lines up with the P
  // edge), so the count is final exactly when HOLD is entered.
  always_comb begin
    cnt_d = cnt_q;
    if (tag_q[1].first)      cnt_d = CNT_W'(1);
    else if (cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      tag_q   <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      opm_q   <= '0;
      rst_q   <= 1'b1;
    end else begin
      rst_q <= 1'b0;

      if (dsp_ce) begin
        tag_q[0] <= '{live: xfer, first: first};
        tag_q[1] <= tag_q[0];
        // Bubbles get OPM_ACC with M=0, so they add nothing.
        opm_q    <= first ? OPM_FIRST : OPM_ACC;
        if (tag_q[1].live) cnt_q <= cnt_d;
      end

      case (state_q)
        IDLE: if (xfer) begin
          state_q <= s_last ? DRAIN : ACCUM;
          drain_q <= '0;
        end
        ACCUM: if (xfer && s_last) begin
          state_q <= DRAIN;
          drain_q <= '0;
        end
        DRAIN: begin
          if (drain_q == DRAIN_END) state_q <= HOLD;
          else                      drain_q <= drain_q + DW'(1);
        end
        HOLD: if (m_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
